frequency_analyzer_manager: RTL and testbench

Controller that sequences a `frequency_analyzer` instance through repeated fixed-length measurement windows. For each window it clears and enables the analyzer, waits the window length, captures `f0_value`/`f1_value`, and classifies the window as symbol 0, symbol 1 or error. Results leave on a valid/ready handshake. It sits between the pixel-capture front end (which drives the analyzer) and the downstream symbol decoder.

---
 rtl/frequency_analyzer_pkg.sv | 21 ++
 rtl/frequency_analyzer_manager_window_timer.sv | 41 ++++
 rtl/frequency_analyzer_manager.sv | 202 ++++++++++++++++++++
 tb/tb_frequency_analyzer_manager.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frequency_analyzer_pkg.sv
// Shared types for the frequency analyzer manager: controller states and the
// per-window symbol decision.
package frequency_analyzer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    MEASURE = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

  typedef struct packed {
    logic symbol;
    logic error;
  } decision_t;

  localparam decision_t DECISION_RESET = '{symbol: 1'b0, error: 1'b0};

endpackage

// File: rtl/frequency_analyzer_manager_window_timer.sv
// Loadable down-counter; terminal_pulse fires for exactly one cycle when a
// loaded count reaches zero (value N gives the pulse N cycles after the load).
module window_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             terminal_pulse
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             armed_q, armed_d;

  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (load) begin
      count_d = load_value;
      armed_d = 1'b1;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end else begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

  assign terminal_pulse = armed_q && (count_q == '0);

endmodule

// File: rtl/frequency_analyzer_manager.sv
// Sequences a frequency_analyzer through back-to-back measurement windows and
// emits one classified symbol per window. FREQUENCY_ANALYZER_MANAGER_OVERRUN_EN
// enables dropping results that wait WINDOW_CYCLES without a handshake.
module frequency_analyzer_manager
  import frequency_analyzer_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 20000,
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned MIN_COUNT     = 4,
  parameter int          VALUE_WIDTH   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  output logic                   analyzer_enable,
  output logic                   analyzer_clear,
  input  logic [VALUE_WIDTH-1:0] f0_value,
  input  logic [VALUE_WIDTH-1:0] f1_value,
  output logic                   symbol_valid,
  input  logic                   symbol_ready,
  output logic                   symbol,
  output logic                   symbol_error,
  output logic                   busy,
  output logic [15:0]            window_count,
  output logic                   overrun
);

  localparam int unsigned MAX_LOAD    = (WINDOW_CYCLES > CLEAR_CYCLES) ? WINDOW_CYCLES : CLEAR_CYCLES;
  localparam int          TIMER_WIDTH = $clog2(MAX_LOAD + 1);
  localparam logic [TIMER_WIDTH-1:0] CLEAR_LOAD  = TIMER_WIDTH'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] WINDOW_LOAD = TIMER_WIDTH'(WINDOW_CYCLES - 1);
  localparam logic [VALUE_WIDTH-1:0] MIN_VALUE   = VALUE_WIDTH'(MIN_COUNT);

  state_t                 state_q, state_d;
  logic                   stop_pending_q, stop_pending_d;
  decision_t              decision_q, decision_d, decision_now;
  logic [15:0]            window_count_q, window_count_d;
  logic                   overrun_q, overrun_d;
  logic                   enable_q, enable_d;
  logic                   clear_q, clear_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   timer_load;
  logic [TIMER_WIDTH-1:0] timer_value;
  logic                   timer_done;
  logic                   leave_output;

  window_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_window_timer (
    .clock          (clock),
    .reset          (reset),
    .load           (timer_load),
    .load_value     (timer_value),
    .terminal_pulse (timer_done)
  );

  // Ties and sub-threshold counts are undecidable and reported as errors.
  always_comb begin
    decision_now = '{symbol: 1'b0, error: 1'b1};
    if (f0_value >= MIN_VALUE && f0_value > f1_value) begin
      decision_now = '{symbol: 1'b0, error: 1'b0};
    end else if (f1_value >= MIN_VALUE && f1_value > f0_value) begin
      decision_now = '{symbol: 1'b1, error: 1'b0};
    end
  end

  always_comb begin
    state_d        = state_q;
    stop_pending_d = stop_pending_q;
    decision_d     = decision_q;
    window_count_d = window_count_q;
    overrun_d      = overrun_q;
    timer_load     = 1'b0;
    timer_value    = CLEAR_LOAD;
    leave_output   = 1'b0;

    if (stop && state_q != IDLE) begin
      stop_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = CLEAR;
          timer_load = 1'b1;
          timer_value = CLEAR_LOAD;
        end
      end
      CLEAR: begin
        if (timer_done) begin
          state_d     = MEASURE;
          timer_load  = 1'b1;
          timer_value = WINDOW_LOAD;
        end
      end
      MEASURE: begin
        if (timer_done) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        decision_d  = decision_now;
        state_d     = OUTPUT;
        timer_load  = 1'b1;
        timer_value = WINDOW_LOAD;
      end
      OUTPUT: begin
        if (symbol_ready) begin
          window_count_d = window_count_q + 16'd1;
          leave_output   = 1'b1;
`ifdef FREQUENCY_ANALYZER_MANAGER_OVERRUN_EN
        end else if (timer_done) begin
          overrun_d    = 1'b1;
          leave_output = 1'b1;
`endif
        end
        // A stop arriving in the final OUTPUT cycle still prevents another window.
        if (leave_output) begin
          if (stop_pending_q || stop) begin
            state_d = IDLE;
          end else begin
            state_d     = CLEAR;
            timer_load  = 1'b1;
            timer_value = CLEAR_LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      stop_pending_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    enable_d = 1'b0;
    clear_d  = 1'b1;
    case (state_d)
      IDLE: begin
        enable_d = 1'b0;
        clear_d  = 1'b0;
      end
      CLEAR: begin
        enable_d = 1'b1;
        clear_d  = 1'b0;
      end
      MEASURE: begin
        enable_d = 1'b1;
        clear_d  = 1'b1;
      end
      default: begin
        enable_d = 1'b0;
        clear_d  = 1'b1;
      end
    endcase
    valid_d = (state_d == OUTPUT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      stop_pending_q <= 1'b0;
      decision_q     <= DECISION_RESET;
      window_count_q <= 16'd0;
      overrun_q      <= 1'b0;
      enable_q       <= 1'b0;
      clear_q        <= 1'b0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      stop_pending_q <= stop_pending_d;
      decision_q     <= decision_d;
      window_count_q <= window_count_d;
      overrun_q      <= overrun_d;
      enable_q       <= enable_d;
      clear_q        <= clear_d;
      valid_q        <= valid_d;
      busy_q         <= busy_d;
    end
  end

  assign analyzer_enable = enable_q;
  assign analyzer_clear  = clear_q;
  assign symbol_valid    = valid_q;
  assign symbol          = decision_q.symbol;
  assign symbol_error    = decision_q.error;
  assign busy            = busy_q;
  assign window_count    = window_count_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_frequency_analyzer_manager.sv
// Directed-plus-random bench for frequency_analyzer_manager; window timing and
// symbol classification are predicted from cycle arithmetic and the decision rules.
module tb_frequency_analyzer_manager;

  localparam int W   = 100;
  localparam int C   = 2;
  localparam int MIN = 4;
`ifdef FREQUENCY_ANALYZER_MANAGER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic        symbol_valid;
  logic        symbol_ready;
  logic        symbol;
  logic        symbol_error;
  logic        busy;
  logic [15:0] window_count;
  logic        overrun;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_count = 16'd0;
  logic        exp_overrun = 1'b0;

  frequency_analyzer_manager #(
    .WINDOW_CYCLES(W),
    .CLEAR_CYCLES (C),
    .MIN_COUNT    (MIN),
    .VALUE_WIDTH  (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .analyzer_enable(analyzer_enable),
    .analyzer_clear (analyzer_clear),
    .f0_value       (f0_value),
    .f1_value       (f1_value),
    .symbol_valid   (symbol_valid),
    .symbol_ready   (symbol_ready),
    .symbol         (symbol),
    .symbol_error   (symbol_error),
    .busy           (busy),
    .window_count   (window_count),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Reference classification straight from the rules: the larger count wins
  // only if it also reaches the threshold.
  function automatic void ref_decide(input logic [31:0] f0, input logic [31:0] f1,
                                     output logic exp_sym, output logic exp_err);
    longint unsigned a = longint'(f0);
    longint unsigned b = longint'(f1);
    exp_sym = 1'b0;
    exp_err = 1'b1;
    if (a >= MIN && a > b) begin
      exp_err = 1'b0;
    end else if (b >= MIN && b > a) begin
      exp_sym = 1'b1;
      exp_err = 1'b0;
    end
  endfunction

  // Entered on the first CLEAR cycle; leaves on the cycle after the window ends.
  task automatic applyStimulus(input logic [31:0] f0v, input logic [31:0] f1v,
                               input int ready_delay, input bit pulse_stop);
    logic exp_sym;
    logic exp_err;
    bit   dropped;
    int   held;
    ref_decide(f0v, f1v, exp_sym, exp_err);
    dropped  = OVR_EN && (ready_delay >= W);
    held     = dropped ? W : ready_delay;
    f0_value = f0v;
    f1_value = f1v;

    for (int off = 0; off <= C + W + 1; off++) begin
      if (off <= C + W) begin
        checkOutput("analyzer_enable", {31'd0, analyzer_enable}, {31'd0, off < C + W});
        checkOutput("analyzer_clear", {31'd0, analyzer_clear}, {31'd0, off >= C});
      end
      checkOutput("symbol_valid_early", {31'd0, symbol_valid}, 32'd0);
      checkOutput("busy_in_window", {31'd0, busy}, 32'd1);
      start = (off == C + 5);
      stop  = pulse_stop && (off == C + W / 2);
      tick();
      start = 1'b0;
      stop  = 1'b0;
    end

    for (int k = 0; k < held; k++) begin
      checkOutput("symbol_valid_hold", {31'd0, symbol_valid}, 32'd1);
      checkOutput("symbol_hold", {31'd0, symbol}, {31'd0, exp_sym});
      checkOutput("symbol_error_hold", {31'd0, symbol_error}, {31'd0, exp_err});
      checkOutput("overrun_hold", {31'd0, overrun}, {31'd0, exp_overrun});
      symbol_ready = 1'b0;
      tick();
    end

    if (!dropped) begin
      checkOutput("symbol_valid", {31'd0, symbol_valid}, 32'd1);
      checkOutput("symbol", {31'd0, symbol}, {31'd0, exp_sym});
      checkOutput("symbol_error", {31'd0, symbol_error}, {31'd0, exp_err});
      symbol_ready = 1'b1;
      tick();
      symbol_ready = 1'b0;
      exp_count++;
    end else begin
      exp_overrun = 1'b1;
    end

    checkOutput("symbol_valid_after", {31'd0, symbol_valid}, 32'd0);
    checkOutput("window_count", {16'd0, window_count}, {16'd0, exp_count});
    checkOutput("overrun", {31'd0, overrun}, {31'd0, exp_overrun});
    if (pulse_stop) begin
      checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
      checkOutput("enable_after_stop", {31'd0, analyzer_enable}, 32'd0);
    end else begin
      checkOutput("busy_restart", {31'd0, busy}, 32'd1);
      checkOutput("enable_restart", {31'd0, analyzer_enable}, 32'd1);
      checkOutput("clear_restart", {31'd0, analyzer_clear}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    symbol_ready = 1'b0;
    f0_value     = 32'd0;
    f1_value     = 32'd0;
    repeat (3) tick();

    checkOutput("reset_enable", {31'd0, analyzer_enable}, 32'd0);
    checkOutput("reset_clear", {31'd0, analyzer_clear}, 32'd0);
    checkOutput("reset_valid", {31'd0, symbol_valid}, 32'd0);
    checkOutput("reset_symbol", {31'd0, symbol}, 32'd0);
    checkOutput("reset_error", {31'd0, symbol_error}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_window_count", {16'd0, window_count}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;

    while (cyc < 10) tick();
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;

    applyStimulus(32'd50, 32'd3, 0, 1'b0);
    applyStimulus(32'd7, 32'd7, 0, 1'b0);
    applyStimulus(32'd2, 32'd3, 0, 1'b0);
    applyStimulus(32'h8000_0000, 32'd5, 40, 1'b0);
    applyStimulus(32'd3, 32'd4, 2, 1'b0);

    for (int i = 0; i < 5; i++) begin
      ra = $urandom_range(0, 12);
      rb = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) ra = $urandom();
      if ($urandom_range(0, 3) == 0) rb = $urandom();
      applyStimulus(ra, rb, int'($urandom_range(0, 3)), 1'b0);
    end

    applyStimulus(32'd3, 32'd9, 100, 1'b0);

    ra = $urandom_range(0, 20);
    rb = $urandom_range(0, 20);
    applyStimulus(ra, rb, 1, 1'b1);

    tick();
    checkOutput("idle_stays_idle", {31'd0, busy}, 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("start_stop_busy", {31'd0, busy}, 32'd0);
    checkOutput("start_stop_enable", {31'd0, analyzer_enable}, 32'd0);
    tick();
    checkOutput("start_stop_busy_later", {31'd0, busy}, 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    checkOutput("pre_reset_enable", {31'd0, analyzer_enable}, 32'd1);
    checkOutput("pre_reset_clear", {31'd0, analyzer_clear}, 32'd1);
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    exp_count   = 16'd0;
    exp_overrun = 1'b0;
    checkOutput("midreset_enable", {31'd0, analyzer_enable}, 32'd0);
    checkOutput("midreset_clear", {31'd0, analyzer_clear}, 32'd0);
    checkOutput("midreset_valid", {31'd0, symbol_valid}, 32'd0);
    checkOutput("midreset_symbol", {31'd0, symbol}, 32'd0);
    checkOutput("midreset_error", {31'd0, symbol_error}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_window_count", {16'd0, window_count}, {16'd0, exp_count});
    checkOutput("midreset_overrun", {31'd0, overrun}, {31'd0, exp_overrun});
    repeat (W + C + 5) tick();
    checkOutput("post_reset_valid", {31'd0, symbol_valid}, 32'd0);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
